// File: rtl/frame_sched_pkg.sv
// Shared definitions for the per-frame update scheduler and the VGA timing generator.
//   - seq_state_e : sequencer FSM states (idle, requesting a client, sequence done)
//   - Vga*        : 640x480 raster timing constants (visible / total, both axes)
//   - clog2_min1  : ceil(log2(v)), never less than 1, for sizing counters and indices
package frame_sched_pkg;

  localparam int unsigned VgaHVisible = 640;
  localparam int unsigned VgaHTotal   = 800;
  localparam int unsigned VgaVVisible = 480;
  localparam int unsigned VgaVTotal   = 525;

  // Width of the raster counters driven by the timing generator.
  localparam int unsigned PixelW = 10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2
  } seq_state_e;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/frame_event_detect.sv
// Raster event detector: registers the raster position comparisons and emits one-cycle
// pulses, one cycle after the matching pixel is presented.
// Ports:
//   clk_i, rst_i     pixel clock, asynchronous active-high reset
//   pixel_x_i/y_i    raster counters from the timing generator
//   vblank_start_o   pulse: raster reached (0, VVisible)
//   frame_end_o      pulse: raster reached (HTotal-1, VTotal-1)
module frame_event_detect
  import frame_sched_pkg::*;
#(
  parameter int unsigned HTotal   = VgaHTotal,
  parameter int unsigned VVisible = VgaVVisible,
  parameter int unsigned VTotal   = VgaVTotal
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [PixelW-1:0] pixel_x_i,
  input  logic [PixelW-1:0] pixel_y_i,
  output logic              vblank_start_o,
  output logic              frame_end_o
);

  logic vblank_hit, frame_hit;
  logic vblank_hit_q, frame_hit_q;
  logic vblank_start_d, vblank_start_q;
  logic frame_end_d, frame_end_q;

  assign vblank_hit = (pixel_x_i == '0) && (pixel_y_i == PixelW'(VVisible));
  assign frame_hit  = (pixel_x_i == PixelW'(HTotal - 1)) && (pixel_y_i == PixelW'(VTotal - 1));

  // Rising-edge qualification keeps the pulses one cycle wide even if the raster stalls.
  always_comb begin
    vblank_start_d = vblank_hit & ~vblank_hit_q;
    frame_end_d    = frame_hit & ~frame_hit_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vblank_hit_q   <= 1'b0;
      frame_hit_q    <= 1'b0;
      vblank_start_q <= 1'b0;
      frame_end_q    <= 1'b0;
    end else begin
      vblank_hit_q   <= vblank_hit;
      frame_hit_q    <= frame_hit;
      vblank_start_q <= vblank_start_d;
      frame_end_q    <= frame_end_d;
    end
  end

  assign vblank_start_o = vblank_start_q;
  assign frame_end_o    = frame_end_q;

endmodule

// File: rtl/frame_update_sequencer.sv
// Per-frame update scheduler. At the start of vertical blanking it grants update slots to
// N_CLIENTS clients in fixed priority order (client 0 first) with a req/ack handshake and a
// per-client timeout, and flags any sequence still running when the next frame begins.
// Optional feature macro: FRAME_SKIP_EN adds skip_frames[3:0]; a sequence then starts only
// on every (skip_frames+1)-th qualifying vblank.
// Ports:
//   vga_clk, rst       pixel clock, asynchronous active-high reset
//   pixel_x, pixel_y   raster counters
//   enable             gates new sequences; a running sequence always completes
//   upd_ack            per-client done strobes (only the active client's bit counts)
//   upd_req            one-hot-or-zero update request
//   busy               any request asserted
//   seq_done           one-cycle pulse on normal completion
//   timeout_flags      sticky per-client timeout bits, cleared at sequence start
//   overrun            sticky, set when a sequence is aborted at end of frame
//   frame_cnt          number of sequences started (wraps)
//   skip_frames        (FRAME_SKIP_EN only) frames to skip between sequences
module frame_update_sequencer
  import frame_sched_pkg::*;
#(
  parameter int unsigned N_CLIENTS   = 3,
  parameter int unsigned H_TOTAL     = VgaHTotal,
  parameter int unsigned V_VISIBLE   = VgaVVisible,
  parameter int unsigned V_TOTAL     = VgaVTotal,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                 vga_clk,
  input  logic                 rst,
  input  logic [PixelW-1:0]    pixel_x,
  input  logic [PixelW-1:0]    pixel_y,
  input  logic                 enable,
`ifdef FRAME_SKIP_EN
  input  logic [3:0]           skip_frames,
`endif
  input  logic [N_CLIENTS-1:0] upd_ack,
  output logic [N_CLIENTS-1:0] upd_req,
  output logic                 busy,
  output logic                 seq_done,
  output logic [N_CLIENTS-1:0] timeout_flags,
  output logic                 overrun,
  output logic [15:0]          frame_cnt
);

  localparam int unsigned IdxW = clog2_min1(N_CLIENTS);
  localparam int unsigned TmoW = clog2_min1(TIMEOUT_CYC);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_CLIENTS - 1);
  localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT_CYC - 1);

  logic vblank_start, frame_end;

  frame_event_detect #(
    .HTotal  (H_TOTAL),
    .VVisible(V_VISIBLE),
    .VTotal  (V_TOTAL)
  ) u_event_detect (
    .clk_i         (vga_clk),
    .rst_i         (rst),
    .pixel_x_i     (pixel_x),
    .pixel_y_i     (pixel_y),
    .vblank_start_o(vblank_start),
    .frame_end_o   (frame_end)
  );

  seq_state_e          state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [N_CLIENTS-1:0] upd_req_q, upd_req_d;
  logic                busy_q, busy_d;
  logic                seq_done_q, seq_done_d;
  logic [N_CLIENTS-1:0] flags_q, flags_d;
  logic                overrun_q, overrun_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;

  logic qualify, start, ack_hit, tmo_hit, is_last;

  // upd_req_q is one-hot on the active client, so masking acks with it ignores strays.
  assign ack_hit = |(upd_ack & upd_req_q);
  assign tmo_hit = (tmo_q == TmoMax);
  assign is_last = (idx_q == LastIdx);
  assign qualify = vblank_start && enable && (state_q == StIdle);

`ifdef FRAME_SKIP_EN
  logic [3:0] skip_q, skip_d;

  always_comb begin
    skip_d = skip_q;
    start  = 1'b0;
    if (qualify) begin
      // >= also recovers if skip_frames is lowered while the counter is mid-count.
      if (skip_q >= skip_frames) begin
        start  = 1'b1;
        skip_d = '0;
      end else begin
        skip_d = skip_q + 4'd1;
      end
    end
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) skip_q <= '0;
    else     skip_q <= skip_d;
  end
`else
  assign start = qualify;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    upd_req_d   = upd_req_q;
    seq_done_d  = 1'b0;
    flags_d     = flags_q;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StReq;
          idx_d        = '0;
          tmo_d        = '0;
          upd_req_d    = '0;
          upd_req_d[0] = 1'b1;
          flags_d      = '0;
          frame_cnt_d  = frame_cnt_q + 16'd1;
        end
      end

      StReq: begin
        // A final ack landing with frame_end still counts as a normal completion.
        if (frame_end && !(ack_hit && is_last)) begin
          state_d   = StIdle;
          upd_req_d = '0;
          overrun_d = 1'b1;
        end else if (ack_hit || tmo_hit) begin
          if (!ack_hit) flags_d = flags_q | upd_req_q;
          tmo_d = '0;
          if (is_last) begin
            state_d   = StDone;
            upd_req_d = '0;
          end else begin
            idx_d     = idx_q + 1'b1;
            upd_req_d = upd_req_q << 1;
          end
        end else begin
          tmo_d = tmo_hit ? tmo_q : tmo_q + 1'b1;
        end
      end

      StDone: begin
        seq_done_d = 1'b1;
        state_d    = StIdle;
      end

      default: begin
        state_d   = StIdle;
        upd_req_d = '0;
      end
    endcase

    busy_d = |upd_req_d;
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      tmo_q       <= '0;
      upd_req_q   <= '0;
      busy_q      <= 1'b0;
      seq_done_q  <= 1'b0;
      flags_q     <= '0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      upd_req_q   <= upd_req_d;
      busy_q      <= busy_d;
      seq_done_q  <= seq_done_d;
      flags_q     <= flags_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign upd_req       = upd_req_q;
  assign busy          = busy_q;
  assign seq_done      = seq_done_q;
  assign timeout_flags = flags_q;
  assign overrun       = overrun_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_frame_update_sequencer.sv
// Scoreboard bench for frame_update_sequencer on a shrunken raster (32 x 5 lines, 4 visible)
// with TIMEOUT_CYC=16. Stimulus pushes hand-computed events; a monitor pops and compares.
// Event times (c) are pixel cycles counted from the cycle the raster shows (0, V_VISIBLE).
module tb_frame_update_sequencer;

  localparam int unsigned N     = 3;
  localparam int unsigned HT    = 32;
  localparam int unsigned VV    = 4;
  localparam int unsigned VT    = 5;
  localparam int unsigned TMO   = 16;
  localparam int          NEVER = 1000;

  localparam int EvReq   = 0;
  localparam int EvDone  = 1;
  localparam int EvAbort = 2;

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
  } ev_t;

  logic           vga_clk = 1'b0;
  logic           rst;
  logic [9:0]     pixel_x, pixel_y;
  logic           enable;
  logic [N-1:0]   upd_ack;
  logic [N-1:0]   upd_req;
  logic           busy, seq_done, overrun;
  logic [N-1:0]   timeout_flags;
  logic [15:0]    frame_cnt;
`ifdef FRAME_SKIP_EN
  logic [3:0]     skip_frames = 4'd0;
`endif

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  int  px, py, rel;
  int  delay[N];
  int  cnt[N];
  bit  spurious;

  frame_update_sequencer #(
    .N_CLIENTS  (N),
    .H_TOTAL    (HT),
    .V_VISIBLE  (VV),
    .V_TOTAL    (VT),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .vga_clk      (vga_clk),
    .rst          (rst),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .enable       (enable),
`ifdef FRAME_SKIP_EN
    .skip_frames  (skip_frames),
`endif
    .upd_ack      (upd_ack),
    .upd_req      (upd_req),
    .busy         (busy),
    .seq_done     (seq_done),
    .timeout_flags(timeout_flags),
    .overrun      (overrun),
    .frame_cnt    (frame_cnt)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int a, input int b, input int c);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  function automatic string kname(input int k);
    return (k == EvReq) ? "req" : (k == EvDone) ? "done" : "abort";
  endfunction

  task automatic got(input int kind, input int a, input int b, input int c);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got a=%0d b=%0d c=%0d, none expected", kname(kind), a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a != a || e.b != b || e.c != c) begin
        errors++;
        $display("FAIL event_%s: got %s a=%0d b=%0d c=%0d expected %s a=%0d b=%0d c=%0d",
                 kname(e.kind), kname(kind), a, b, c, kname(e.kind), e.a, e.b, e.c);
      end
    end
  endtask

  // Raster generator and client models, all driven on the falling edge.
  initial begin
    px = HT - 1; py = VT - 1; rel = 0;
    pixel_x = 10'(px); pixel_y = 10'(py);
    upd_ack = '0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    forever begin
      @(negedge vga_clk);
      if (px == HT - 1) begin
        px = 0;
        py = (py == VT - 1) ? 0 : py + 1;
      end else begin
        px++;
      end
      rel = (px == 0 && py == VV) ? 0 : rel + 1;
      pixel_x = 10'(px); pixel_y = 10'(py);
      for (int i = 0; i < N; i++) begin
        if (upd_req[i]) begin
          upd_ack[i] = (cnt[i] == delay[i]);
          cnt[i]++;
        end else begin
          upd_ack[i] = 1'b0;
          cnt[i] = 0;
        end
      end
      if (spurious && upd_req[0]) upd_ack[2] = 1'b1;
    end
  end

  // Monitor: turns output activity into events and checks them against the scoreboard.
  initial begin
    logic [N-1:0] prev_req;
    logic         prev_ovr;
    int           start_rel[N];
    int           len[N];
    prev_req = '0;
    prev_ovr = 1'b0;
    for (int i = 0; i < N; i++) begin start_rel[i] = 0; len[i] = 0; end
    forever begin
      @(posedge vga_clk);
      #1;
      check("busy_vs_req", int'(busy), int'(upd_req != '0));
      check("req_onehot0", int'($onehot0(upd_req)), 1);
      for (int i = 0; i < N; i++) begin
        if (prev_req[i] && !upd_req[i]) got(EvReq, i, len[i], start_rel[i]);
        if (!prev_req[i] && upd_req[i]) begin start_rel[i] = rel; len[i] = 0; end
        if (upd_req[i]) len[i]++;
      end
      if (seq_done) got(EvDone, int'(timeout_flags), int'(frame_cnt), rel);
      if (overrun && !prev_ovr) got(EvAbort, int'(upd_req), int'(frame_cnt), rel);
      prev_req = upd_req;
      prev_ovr = overrun;
    end
  end

  // Configure the upcoming frame at the start of visible line 1.
  task automatic run_frame(input int d0, input int d1, input int d2, input bit en,
                           input bit spur);
    do begin
      @(negedge vga_clk);
      #1;
    end while (!(px == 0 && py == 1));
    delay[0] = d0; delay[1] = d1; delay[2] = d2;
    enable   = en;
    spurious = spur;
  endtask

  task automatic expect_normal3(input int fc);
    push(EvReq, 0, 3, 1);
    push(EvReq, 1, 3, 4);
    push(EvReq, 2, 3, 7);
    push(EvDone, 0, fc, 11);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; spurious = 1'b0;
    delay[0] = 2; delay[1] = 2; delay[2] = 2;
    repeat (3) @(negedge vga_clk);
    #1;
    check("reset_upd_req", int'(upd_req), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_seq_done", int'(seq_done), 0);
    check("reset_flags", int'(timeout_flags), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_frame_cnt", int'(frame_cnt), 0);
    #1 rst = 1'b0;

    // 1: every client acks 2 cycles after request (held 3 cycles each).
    run_frame(2, 2, 2, 1'b1, 1'b0);
    expect_normal3(1);
    // 2: immediate acks, seq_done N+1 cycles after the start edge.
    run_frame(0, 0, 0, 1'b1, 1'b0);
    push(EvReq, 0, 1, 1); push(EvReq, 1, 1, 2); push(EvReq, 2, 1, 3);
    push(EvDone, 0, 2, 5);
    // 3: client 1 never acks; held exactly TMO cycles, flag bit 1, client 2 still served.
    run_frame(2, NEVER, 2, 1'b1, 1'b0);
    push(EvReq, 0, 3, 1); push(EvReq, 1, 16, 4); push(EvReq, 2, 3, 20);
    push(EvDone, 3'b010, 3, 24);
    // 4: client 1 acks in the very cycle the timeout is reached: ack wins.
    run_frame(2, 15, 2, 1'b1, 1'b0);
    push(EvReq, 0, 3, 1); push(EvReq, 1, 16, 4); push(EvReq, 2, 3, 20);
    push(EvDone, 0, 4, 24);
    // 5: stray ack on client 2 while client 0 is active changes nothing.
    run_frame(2, 2, 2, 1'b1, 1'b1);
    expect_normal3(5);
    // 6: client 2 stalls past frame_end: abort, overrun, requests dropped.
    run_frame(2, 14, NEVER, 1'b1, 1'b0);
    push(EvReq, 0, 3, 1); push(EvReq, 1, 15, 4); push(EvReq, 2, 13, 19);
    push(EvAbort, 0, 6, 32);
    // 7: next frame restarts cleanly at client 0.
    run_frame(2, 2, 2, 1'b1, 1'b0);
    expect_normal3(7);
    // 8: disabled, nothing starts and frame_cnt does not move.
    run_frame(2, 2, 2, 1'b0, 1'b0);
    // 9: enabled again.
    run_frame(2, 2, 2, 1'b1, 1'b0);
    expect_normal3(8);
    // 10: reset pulsed in the middle of client 1's request.
    run_frame(2, NEVER, 2, 1'b1, 1'b0);
    push(EvReq, 0, 3, 1); push(EvReq, 1, 3, 4);
    check("overrun_sticky", int'(overrun), 1);
    do begin
      @(negedge vga_clk);
      #1;
    end while (!(py == VV && rel == 7));
    #1 rst = 1'b1;
    #1;
    check("async_rst_upd_req", int'(upd_req), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_overrun", int'(overrun), 0);
    check("async_rst_frame_cnt", int'(frame_cnt), 0);
    @(negedge vga_clk);
    #2 rst = 1'b0;
    // 11: clean restart after reset.
    run_frame(2, 2, 2, 1'b1, 1'b0);
    expect_normal3(1);
    run_frame(2, 2, 2, 1'b0, 1'b0);
    check("pending_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/frame_update_sequencer.md
# frame_update_sequencer

Per-frame scheduler for the game-logic clients that share the vertical blanking window of the 640x480 VGA raster. It watches `pixel_x`/`pixel_y` from the VGA timing generator and detects the start of vertical blanking. At that point it grants update slots to N clients one at a time using a req/ack handshake, with a per-client timeout. It reports completion, timeouts, and any sequence still running when the next visible frame begins.

## Interface
- `N_CLIENTS`, 3: number of update clients, fixed priority; index 0 runs first. Range 1..8.
- `H_TOTAL`, 800: pixels per line, including blanking.
- `V_VISIBLE`, 480: visible lines.
- `V_TOTAL`, 525: lines per frame.
- `TIMEOUT_CYC`, 4096: maximum cycles a request may stay unacknowledged.

- `vga_clk`  in  1  pixel clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `pixel_x`  in  10  horizontal counter from the timing generator.
- `pixel_y`  in  10  vertical counter from the timing generator.
- `enable`  in  1  when low, no new sequence starts; a running sequence completes.
- `upd_ack`  in  N_CLIENTS  client done strobes; only the bit of the active client is honoured.
- `upd_req`  out  N_CLIENTS  one-hot or zero update request.
- `busy`  out  1  high while any request is asserted.
- `seq_done`  out  1  one-cycle pulse when a sequence completes normally.
- `timeout_flags`  out  N_CLIENTS  per-client sticky timeout bits; cleared at each sequence start.
- `overrun`  out  1  sticky; set when a sequence is aborted at end of frame.
- `frame_cnt`  out  16  count of sequences started.

Clock is `vga_clk`, reset is `rst`: asynchronous, active-high.

## Operation
- Reset values: all outputs are 0, the FSM is in IDLE, and the timeout counter is 0.
- `vblank_start` is true when `pixel_x==0 && pixel_y==V_VISIBLE`.
- `frame_end` is true when `pixel_x==H_TOTAL-1 && pixel_y==V_TOTAL-1`.
- State IDLE: on `vblank_start && enable`:
  - go to REQ with index 0;
  - clear `timeout_flags`;
  - increment `frame_cnt` (wraps 0xFFFF to 0).
- State REQ(i): `upd_req[i]=1`. Leaving REQ(i):
  - If `upd_ack[i]` is sampled high, go to REQ(i+1), or to DONE if `i==N_CLIENTS-1`.
  - If the timeout counter reaches TIMEOUT_CYC-1 without an ack, set `timeout_flags[i]` and advance the same way.
  - If an ack and the timeout occur in the same cycle, the ack wins and no flag is set.
- State DONE: `seq_done=1` for one cycle, then return to IDLE.
- Abort: `frame_end` while in REQ:
  - set `overrun`;
  - drop `upd_req`;
  - go to IDLE with no `seq_done`.
  - `frame_end` in the same cycle as the final ack counts as a normal completion, not an abort.
- `overrun` is cleared only by `rst`.
- `vblank_start` while not in IDLE is ignored. This cannot occur when the inputs are legal.
- An ack on an inactive client bit is ignored and has no side effects.
- Asserting `rst` mid-sequence returns everything to reset values immediately; clients see `upd_req` drop asynchronously.

## Timing
- Registered outputs only; no combinational path from input to output.
- Edge E samples `vblank_start`. `upd_req[0]` and `busy` go high after E; `frame_cnt` updates at E.
- Handoff: the edge that samples `upd_ack[i]` both deasserts `upd_req[i]` and asserts `upd_req[i+1]`. No idle cycle between clients.
- Minimum sequence: with clients acking in the first request cycle, `seq_done` pulses N_CLIENTS+1 cycles after E.
- Timeout counter:
  - restarts at 0 on each REQ entry;
  - a client that never acks holds its request for exactly TIMEOUT_CYC cycles.
- Width rule: the timeout counter is `$clog2(TIMEOUT_CYC)` bits and saturates, never wraps.

## Configuration
- `FRAME_SKIP_EN` defined:
  - adds input `skip_frames` (4 bits);
  - a sequence starts only on every (`skip_frames`+1)-th qualifying `vblank_start`;
  - a 4-bit skip counter resets to 0, increments on each qualifying `vblank_start`, and reloads when it matches;
  - `frame_cnt` counts only started sequences;
  - with `skip_frames=0`, behaviour is identical to the macro-undefined build.
- `FRAME_SKIP_EN` undefined: no port, no counter; every enabled frame runs.

## Structure
- Shared package `frame_sched_pkg` holds:
  - the FSM state enum (IDLE, REQ, DONE);
  - the VGA timing constants (640/800 horizontal, 480/525 vertical), also consumed by the timing generator.
- One sub-module, `frame_event_detect`: registers the raster comparisons and emits one-cycle `vblank_start` and `frame_end` pulses.
- The FSM, index register, and timeout counter live in the top module.

## Test plan
- Reset, then full raster with all clients acking 2 cycles after request:
  - requests run in order 0,1,2, each held 3 cycles;
  - `seq_done` fires once per frame;
  - `frame_cnt` reads 1 after the first frame;
  - `timeout_flags`=0.
- Client 1 never acks, TIMEOUT_CYC=16:
  - `upd_req[1]` is high exactly 16 cycles;
  - `timeout_flags`=3'b010;
  - client 2 is still served;
  - `seq_done` fires.
- Client 2 stalls past `frame_end` (TIMEOUT_CYC large):
  - `overrun`=1 and `upd_req`=0 on the next cycle;
  - no `seq_done`;
  - the next frame restarts at client 0.
- Ack on client 2 while client 0 is active: ignored; order and timing are unchanged. Ack and timeout in the same cycle: flag stays 0.
- `rst` pulsed mid-REQ(1): all outputs go to 0 without waiting for an edge; the FSM restarts cleanly on the next `vblank_start`.
- `FRAME_SKIP_EN` build with `skip_frames=2`: over 9 frames, sequences start on frames 3, 6 and 9; `frame_cnt`=3.
